// File: rtl/bayer_pkg.sv
// Shared types for the raw Bayer 2x2 window generator.
// Holds the FSM state encoding, the pixel width and the packed window record.
package bayer_pkg;

  localparam int PIX_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    STREAM,
    FLUSH
  } state_t;

  typedef struct packed {
    logic [PIX_W-1:0] wb_1;
    logic [PIX_W-1:0] wb_2;
    logic [PIX_W-1:0] wb_3;
    logic [PIX_W-1:0] wb_4;
    logic             row;
    logic             col;
  } window_t;

endpackage

// File: rtl/bayer_window_line_buffer.sv
// One image row of pixels: combinational read and synchronous write at a shared address,
// so a read in the same cycle as a write still returns the previous row's pixel.
module line_buffer
  import bayer_pkg::*;
#(
  parameter int DEPTH = 640,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    addr,
  input  logic [PIX_W-1:0] wdata,
  output logic [PIX_W-1:0] rdata
);

  logic [PIX_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/bayer_window.sv
// Streaming 2x2 window generator: buffers one row and emits every overlapping
// 2x2 neighbourhood with the parity of its top-left pixel, under valid/ready flow control.
module bayer_window
  import bayer_pkg::*;
#(
  parameter int IMG_W = 640,
  parameter int IMG_H = 480
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [PIX_W-1:0] pix_in,
  input  logic             pix_valid,
  output logic             pix_ready,
  output logic [PIX_W-1:0] wb_1,
  output logic [PIX_W-1:0] wb_2,
  output logic [PIX_W-1:0] wb_3,
  output logic [PIX_W-1:0] wb_4,
  output logic             row,
  output logic             col,
  output logic             win_valid,
  input  logic             win_ready,
  output logic             frame_done
);

  localparam int XW = $clog2(IMG_W);
  localparam int YW = $clog2(IMG_H);

  state_t           state_reg, state_next;
  logic [XW-1:0]    x_reg;
  logic [YW-1:0]    y_reg;
  logic [PIX_W-1:0] top_prev_reg, cur_prev_reg;
  logic [PIX_W-1:0] top;
  window_t          win_reg;
  logic             win_valid_reg;
  logic             frame_done_reg, frame_done_next;
  logic             accept, x_last, y_last, load_win;

  assign pix_ready = (state_reg == FILL) |
                     ((state_reg == STREAM) & (~win_valid_reg | win_ready));
  assign accept    = pix_valid & pix_ready;
  assign x_last    = (x_reg == XW'(IMG_W - 1));
  assign y_last    = (y_reg == YW'(IMG_H - 1));
  assign load_win  = accept & (state_reg == STREAM) & (x_reg != '0);

  line_buffer #(
    .DEPTH (IMG_W),
    .AW    (XW)
  ) u_line_buffer (
    .clk   (clk),
    .we    (accept),
    .addr  (x_reg),
    .wdata (pix_in),
    .rdata (top)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      frame_done_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      frame_done_reg <= frame_done_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    frame_done_next = 1'b0;
    case (state_reg)
      IDLE:   if (start) state_next = FILL;
      FILL:   if (accept && x_last) state_next = STREAM;
      STREAM: if (accept && x_last && y_last) state_next = FLUSH;
      FLUSH: begin
        if (win_valid_reg && win_ready) begin
          state_next      = IDLE;
          frame_done_next = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      x_reg <= '0;
      y_reg <= '0;
    end else if (state_reg == IDLE && start) begin
      x_reg <= '0;
      y_reg <= '0;
    end else if (accept) begin
      if (x_last) begin
        x_reg <= '0;
        y_reg <= y_reg + YW'(1);
      end else begin
        x_reg <= x_reg + XW'(1);
      end
    end
  end

  // Parity of (v-1) is simply the inverse of v's LSB.
  always_ff @(posedge clk) begin
    if (rst) begin
      top_prev_reg  <= '0;
      cur_prev_reg  <= '0;
      win_reg       <= '0;
      win_valid_reg <= 1'b0;
    end else begin
      if (accept) begin
        top_prev_reg <= top;
        cur_prev_reg <= pix_in;
      end
      if (load_win) begin
        win_reg.wb_1  <= top_prev_reg;
        win_reg.wb_2  <= top;
        win_reg.wb_3  <= cur_prev_reg;
        win_reg.wb_4  <= pix_in;
        win_reg.row   <= ~y_reg[0];
        win_reg.col   <= ~x_reg[0];
        win_valid_reg <= 1'b1;
      end else if (win_ready) begin
        win_valid_reg <= 1'b0;
      end
    end
  end

  assign wb_1       = win_reg.wb_1;
  assign wb_2       = win_reg.wb_2;
  assign wb_3       = win_reg.wb_3;
  assign wb_4       = win_reg.wb_4;
  assign row        = win_reg.row;
  assign col        = win_reg.col;
  assign win_valid  = win_valid_reg;
  assign frame_done = frame_done_reg;

endmodule

// File: doc/bayer_window.md
# bayer_window

Streaming 2x2 window generator for the raw Bayer pipeline. It accepts one 8-bit white-balanced raw pixel per handshake in raster order. It keeps one image row in a line buffer and emits every overlapping 2x2 neighbourhood as four pixels, together with the row/column parity of the window's top-left pixel. Its output feeds the RGGB channel-assignment mux directly: wb_1..wb_4, row and col connect port-for-port.

## Interface
- IMG_W, default 640: image width in pixels, ≥ 2.
- IMG_H, default 480: image height in rows, ≥ 2.

- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle frame-start request; honoured only in IDLE.
- pix_in  in  8  raw pixel.
- pix_valid  in  1  pix_in valid.
- pix_ready  out  1  block accepts pix_in this cycle.
- wb_1  out  8  window top-left, pixel (x-1, y-1).
- wb_2  out  8  window top-right, pixel (x, y-1).
- wb_3  out  8  window bottom-left, pixel (x-1, y).
- wb_4  out  8  window bottom-right, pixel (x, y).
- row  out  1  (y-1)[0], top-left row parity.
- col  out  1  (x-1)[0], top-left column parity.
- win_valid  out  1  window outputs valid.
- win_ready  in  1  downstream accepts the window.
- frame_done  out  1  one-cycle pulse after the last window is accepted.

## Operation
- States:
  - IDLE: pix_ready=0. On start, go to FILL; x=0, y=0.
  - FILL: row 0 only. Each accepted pixel is written to linebuf[x] and to register cur_prev. No window is produced.
  - STREAM: rows 1..IMG_H-1. For each accepted pixel at (x, y):
    - read top=linebuf[x]; write linebuf[x]=pix_in (read-before-write at the same address);
    - keep top_prev (top of the previous column) and cur_prev (previous pixel of this row);
    - if x≥1, load the output register: wb_1=top_prev, wb_2=top, wb_3=cur_prev, wb_4=pix_in, row=(y-1)[0], col=(x-1)[0]; set win_valid=1.
  - FLUSH: entered after the final pixel (IMG_W-1, IMG_H-1) is accepted. Wait for the final window handshake, then pulse frame_done and return to IDLE.
- Counters:
  - x counts 0..IMG_W-1 and wraps to 0 on the last column; y increments on that wrap.
  - x is $clog2(IMG_W) bits wide; y is $clog2(IMG_H) bits wide.
  - FILL→STREAM transition happens when x wraps in row 0.
- Handshake:
  - pix_ready = (state==FILL) | (state==STREAM & (~win_valid | win_ready)).
  - A pixel is accepted when pix_valid & pix_ready.
  - win_valid clears on win_valid & win_ready unless a new window loads in the same cycle.
  - While win_valid & ~win_ready, all window outputs hold stable.
- Per-frame output: exactly (IMG_W-1)*(IMG_H-1) windows. Column x=0 of every row produces no window.
- Edge cases:
  - start outside IDLE is ignored.
  - pix_valid in IDLE is ignored and no pixel is consumed.
  - Reset mid-frame returns the block to IDLE with all outputs zero. linebuf contents are not cleared; FILL rewrites them.

## Timing
- Reset values: pix_ready=0, win_valid=0, wb_1..wb_4=0, row=0, col=0, frame_done=0, state=IDLE.
- Latency: a window is valid the cycle after its bottom-right pixel is accepted.
- Throughput: one pixel per cycle under continuous valid/ready, with no bubble at row boundaries.
- The simultaneous handshake (window leaving while the next loads) sustains full rate.
- frame_done is asserted the cycle after the final window handshake. pix_ready becomes 1 one cycle after start is sampled in IDLE.

## Structure
- Package bayer_pkg:
  - state enum (IDLE, FILL, STREAM, FLUSH);
  - PIX_W=8;
  - window struct {wb_1, wb_2, wb_3, wb_4, row, col}.
- Sub-module line_buffer: IMG_W x 8 register array with a combinational read port and a synchronous write port at the same address, write-enable gated by acceptance. Cleared on rst is not required.
- Top level holds the FSM, counters, top_prev/cur_prev and the output register.

## Test plan
- 4x3 frame, pixel value = raster index 0..11, pix_valid and win_ready held high → 6 windows in order:
  - (0,1,4,5 r0 c0), (1,2,5,6 r0 c1), (2,3,6,7 r0 c0), (4,5,8,9 r1 c0), (5,6,9,10 r1 c1), (6,7,10,11 r1 c0);
  - then one frame_done pulse, then IDLE.
- Same frame with win_ready low for 5 cycles at the first window → outputs held at (0,1,4,5), pix_ready=0 throughout, no pixel lost, identical sequence afterwards.
- pix_valid toggling 1/0 each cycle → same 6 windows; each window appears one cycle after its pixel is accepted.
- start pulsed mid-frame → ignored, output unchanged. pix_valid in IDLE → pix_ready=0 and nothing is consumed.
- rst asserted after pixel 6 → next cycle all outputs 0 and state IDLE. A fresh start and full frame then reproduce the case-1 sequence.
- Two back-to-back 4x3 frames with start issued the cycle after frame_done → 12 windows total; the second frame matches the first with values offset by +12.
